roce_write_segmenter_64: RTL and testbench

// - Downstream of the UDP RoCE connection manager. Takes the QP parameters and the start_transfer level it emits, and splits one DMA transfer into PMTU-sized RDMA WRITE packets.
// - Emits one header descriptor per packet (BTH/RETH fields plus payload length) to the RoCE TX header builder over a valid/ready handshake.

---
 rtl/roce_write_segmenter_64.sv | 263 ++++++++++++++++++++++++++
 tb/tb_roce_write_segmenter_64.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roce_write_segmenter_64.sv
// -----------------------------------------------------------------------------
// roce_write_segmenter_64
//
// Splits one DMA transfer into PMTU-sized RDMA WRITE packets and emits one
// header descriptor per packet (BTH/RETH fields plus payload length) to the
// RoCE TX header builder over a valid/ready handshake.
//
// A rising edge on start_transfer captures the QP parameters. Two cycles after
// that edge the first descriptor is presented. Each accepted descriptor
// advances the PSN (mod 2^24) and consumes PMTU bytes from the remaining
// length. The final descriptor (LAST or ONLY) returns the block to IDLE and
// pulses done one cycle later.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start_transfer      level; a rising edge requests a transfer
//   dma_length          transfer length in bytes
//   r_key, rem_qpn      remote key, destination QP
//   rem_psn             PSN of the first packet
//   rem_ip_addr         destination IP
//   rem_addr            remote virtual address
//   m_hdr_valid/ready   descriptor handshake
//   m_bth_*             opcode, PSN, destination QP, ack request
//   m_reth_*            RETH present flag, vaddr, rkey, total DMA length
//   m_payload_length    payload bytes in this packet
//   m_ip_dest_ip        destination IP
//   busy                a transfer is in progress
//   done                1-cycle pulse after the final descriptor is accepted
//   start_dropped       1-cycle pulse when a start edge arrives while busy
// -----------------------------------------------------------------------------
module roce_write_segmenter_64 #(
  parameter int unsigned PMTU      = 1024,
  parameter int unsigned PMTU_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_transfer,
  input  logic [31:0] dma_length,
  input  logic [31:0] r_key,
  input  logic [23:0] rem_qpn,
  input  logic [23:0] rem_psn,
  input  logic [31:0] rem_ip_addr,
  input  logic [63:0] rem_addr,
  output logic        m_hdr_valid,
  input  logic        m_hdr_ready,
  output logic [7:0]  m_bth_opcode,
  output logic [23:0] m_bth_psn,
  output logic [23:0] m_bth_dest_qp,
  output logic        m_bth_ack_req,
  output logic        m_reth_valid,
  output logic [63:0] m_reth_vaddr,
  output logic [31:0] m_reth_rkey,
  output logic [31:0] m_reth_length,
  output logic [15:0] m_payload_length,
  output logic [31:0] m_ip_dest_ip,
  output logic        busy,
  output logic        done,
  output logic        start_dropped
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [7:0]  OP_FIRST  = 8'h06;
  localparam logic [7:0]  OP_MIDDLE = 8'h07;
  localparam logic [7:0]  OP_LAST   = 8'h08;
  localparam logic [7:0]  OP_ONLY   = 8'h0A;
  localparam logic [32:0] PMTU_W    = 33'(1) << PMTU_LOG2;
  localparam logic [15:0] PMTU_16   = 16'(PMTU);

  // Sequencing state
  state_e      state_q, state_d;
  logic        start_q;
  logic [32:0] remaining_q, remaining_d;
  logic [23:0] psn_q, psn_d;
  logic        first_q, first_d;

  // Registered descriptor outputs
  logic        hdr_valid_q, hdr_valid_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [23:0] bth_psn_q, bth_psn_d;
  logic [23:0] dest_qp_q, dest_qp_d;
  logic        ack_req_q, ack_req_d;
  logic        reth_valid_q, reth_valid_d;
  logic [63:0] vaddr_q, vaddr_d;
  logic [31:0] rkey_q, rkey_d;
  logic [31:0] length_q, length_d;
  logic [15:0] payload_q, payload_d;
  logic [31:0] ip_q, ip_d;
  logic        done_q, done_d;
  logic        dropped_q, dropped_d;

  // Combinational helpers
  logic        trigger;
  logic        handshake;
  logic        cur_last;
  logic        load;
  logic [32:0] src_rem;
  logic [23:0] src_psn;
  logic        src_first;
  logic        src_last;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree can leave it unassigned and infer a latch.
    trigger   = start_transfer & ~start_q;
    handshake = hdr_valid_q & m_hdr_ready;
    cur_last  = (remaining_q <= PMTU_W);

    state_d      = state_q;
    remaining_d  = remaining_q;
    psn_d        = psn_q;
    first_d      = first_q;
    hdr_valid_d  = hdr_valid_q;
    opcode_d     = opcode_q;
    bth_psn_d    = bth_psn_q;
    dest_qp_d    = dest_qp_q;
    ack_req_d    = ack_req_q;
    reth_valid_d = reth_valid_q;
    vaddr_d      = vaddr_q;
    rkey_d       = rkey_q;
    length_d     = length_q;
    payload_d    = payload_q;
    ip_d         = ip_q;
    done_d       = 1'b0;
    dropped_d    = 1'b0;

    load      = 1'b0;
    src_rem   = remaining_q;
    src_psn   = psn_q;
    src_first = first_q;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          // Per-transfer constants go straight into the output registers;
          // they stay stable for the whole transfer.
          remaining_d = {1'b0, dma_length};
          psn_d       = rem_psn;
          first_d     = 1'b1;
          dest_qp_d   = rem_qpn;
          vaddr_d     = rem_addr;
          rkey_d      = r_key;
          length_d    = dma_length;
          ip_d        = rem_ip_addr;
          state_d     = SEND;
        end
      end

      SEND: begin
        // The final handshake cycle is still SEND, so an edge there is dropped.
        if (trigger) begin
          dropped_d = 1'b1;
        end

        if (!hdr_valid_q) begin
          // First descriptor of the transfer, one cycle after capture.
          load = 1'b1;
        end else if (handshake) begin
          if (cur_last) begin
            hdr_valid_d = 1'b0;
            done_d      = 1'b0 | 1'b1;
            state_d     = IDLE;
          end else begin
            // LAST is taken before this point, so remaining > PMTU here and
            // the subtraction cannot underflow.
            src_rem     = remaining_q - PMTU_W;
            src_psn     = psn_q + 24'd1;
            src_first   = 1'b0;
            remaining_d = src_rem;
            psn_d       = src_psn;
            first_d     = 1'b0;
            load        = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Build the next descriptor from the (possibly advanced) pointer values so
    // back-to-back ready yields one descriptor per cycle.
    src_last = (src_rem <= PMTU_W);
    if (load) begin
      hdr_valid_d  = 1'b1;
      bth_psn_d    = src_psn;
      ack_req_d    = src_last;
      reth_valid_d = src_first;
      payload_d    = src_last ? src_rem[15:0] : PMTU_16;
      if (src_first && src_last) begin
        opcode_d = OP_ONLY;
      end else if (src_first) begin
        opcode_d = OP_FIRST;
      end else if (src_last) begin
        opcode_d = OP_LAST;
      end else begin
        opcode_d = OP_MIDDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its inputs regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      remaining_q  <= '0;
      psn_q        <= '0;
      first_q      <= 1'b0;
      hdr_valid_q  <= 1'b0;
      opcode_q     <= '0;
      bth_psn_q    <= '0;
      dest_qp_q    <= '0;
      ack_req_q    <= 1'b0;
      reth_valid_q <= 1'b0;
      vaddr_q      <= '0;
      rkey_q       <= '0;
      length_q     <= '0;
      payload_q    <= '0;
      ip_q         <= '0;
      done_q       <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_transfer;
      remaining_q  <= remaining_d;
      psn_q        <= psn_d;
      first_q      <= first_d;
      hdr_valid_q  <= hdr_valid_d;
      opcode_q     <= opcode_d;
      bth_psn_q    <= bth_psn_d;
      dest_qp_q    <= dest_qp_d;
      ack_req_q    <= ack_req_d;
      reth_valid_q <= reth_valid_d;
      vaddr_q      <= vaddr_d;
      rkey_q       <= rkey_d;
      length_q     <= length_d;
      payload_q    <= payload_d;
      ip_q         <= ip_d;
      done_q       <= done_d;
      dropped_q    <= dropped_d;
    end
  end

  assign m_hdr_valid      = hdr_valid_q;
  assign m_bth_opcode     = opcode_q;
  assign m_bth_psn        = bth_psn_q;
  assign m_bth_dest_qp    = dest_qp_q;
  assign m_bth_ack_req    = ack_req_q;
  assign m_reth_valid     = reth_valid_q;
  assign m_reth_vaddr     = vaddr_q;
  assign m_reth_rkey      = rkey_q;
  assign m_reth_length    = length_q;
  assign m_payload_length = payload_q;
  assign m_ip_dest_ip     = ip_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign start_dropped    = dropped_q;

endmodule

// File: tb/tb_roce_write_segmenter_64.sv
// -----------------------------------------------------------------------------
// tb_roce_write_segmenter_64
//
// Directed bench for roce_write_segmenter_64 (PMTU = 1024). A reference model
// pushes the expected descriptor sequence of each transfer into a queue when
// the transfer is started; every cycle the valid descriptor is compared to the
// queue head, which is popped on handshake. Done, drop and handshake events
// are counted and checked at the end of each step.
// -----------------------------------------------------------------------------
module tb_roce_write_segmenter_64;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] psn;
    logic [23:0] dest_qp;
    logic        ack_req;
    logic        reth_valid;
    logic [63:0] vaddr;
    logic [31:0] rkey;
    logic [31:0] length;
    logic [15:0] payload;
    logic [31:0] ip;
  } desc_t;

  logic        clk;
  logic        rst_n;
  logic        start_transfer;
  logic [31:0] dma_length;
  logic [31:0] r_key;
  logic [23:0] rem_qpn;
  logic [23:0] rem_psn;
  logic [31:0] rem_ip_addr;
  logic [63:0] rem_addr;
  logic        m_hdr_valid;
  logic        m_hdr_ready;
  logic [7:0]  m_bth_opcode;
  logic [23:0] m_bth_psn;
  logic [23:0] m_bth_dest_qp;
  logic        m_bth_ack_req;
  logic        m_reth_valid;
  logic [63:0] m_reth_vaddr;
  logic [31:0] m_reth_rkey;
  logic [31:0] m_reth_length;
  logic [15:0] m_payload_length;
  logic [31:0] m_ip_dest_ip;
  logic        busy;
  logic        done;
  logic        start_dropped;

  roce_write_segmenter_64 dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_transfer   (start_transfer),
    .dma_length       (dma_length),
    .r_key            (r_key),
    .rem_qpn          (rem_qpn),
    .rem_psn          (rem_psn),
    .rem_ip_addr      (rem_ip_addr),
    .rem_addr         (rem_addr),
    .m_hdr_valid      (m_hdr_valid),
    .m_hdr_ready      (m_hdr_ready),
    .m_bth_opcode     (m_bth_opcode),
    .m_bth_psn        (m_bth_psn),
    .m_bth_dest_qp    (m_bth_dest_qp),
    .m_bth_ack_req    (m_bth_ack_req),
    .m_reth_valid     (m_reth_valid),
    .m_reth_vaddr     (m_reth_vaddr),
    .m_reth_rkey      (m_reth_rkey),
    .m_reth_length    (m_reth_length),
    .m_payload_length (m_payload_length),
    .m_ip_dest_ip     (m_ip_dest_ip),
    .busy             (busy),
    .done             (done),
    .start_dropped    (start_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  desc_t exp_q[$];
  int    vectors;
  int    miscompares;
  int    hs_cnt;
  int    done_cnt;
  int    drop_cnt;
  logic  pending_done;
  logic  prev_stall;
  logic  rand_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: expected descriptor sequence of one transfer.
  task automatic push_transfer(input logic [31:0] len, input logic [23:0] psn0);
    logic [32:0] rem;
    logic [23:0] psn;
    logic        first;
    logic        last;
    desc_t       d;
    rem   = {1'b0, len};
    psn   = psn0;
    first = 1'b1;
    forever begin
      last         = (rem <= 33'd1024);
      d.opcode     = (first && last) ? 8'h0A : first ? 8'h06 : last ? 8'h08 : 8'h07;
      d.psn        = psn;
      d.dest_qp    = rem_qpn;
      d.ack_req    = last;
      d.reth_valid = first;
      d.vaddr      = rem_addr;
      d.rkey       = r_key;
      d.length     = len;
      d.payload    = last ? rem[15:0] : 16'd1024;
      d.ip         = rem_ip_addr;
      exp_q.push_back(d);
      if (last) break;
      rem   = rem - 33'd1024;
      psn   = psn + 24'd1;
      first = 1'b0;
    end
  endtask

  // Output observation, sampled on the falling edge.
  task automatic monitor();
    desc_t e;
    check("done_pulse", done, pending_done);
    pending_done = 1'b0;
    drop_cnt += int'(start_dropped);
    if (prev_stall) check("valid_held", m_hdr_valid, 1'b1);
    prev_stall = m_hdr_valid & ~m_hdr_ready;
    if (m_hdr_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", m_hdr_valid, 1'b0);
      end else begin
        e = exp_q[0];
        check("opcode",     m_bth_opcode,     e.opcode);
        check("psn",        m_bth_psn,        e.psn);
        check("dest_qp",    m_bth_dest_qp,    e.dest_qp);
        check("ack_req",    m_bth_ack_req,    e.ack_req);
        check("reth_valid", m_reth_valid,     e.reth_valid);
        check("vaddr",      m_reth_vaddr,     e.vaddr);
        check("rkey",       m_reth_rkey,      e.rkey);
        check("length",     m_reth_length,    e.length);
        check("payload",    m_payload_length, e.payload);
        check("ip",         m_ip_dest_ip,     e.ip);
        if (m_hdr_ready) begin
          hs_cnt++;
          pending_done = e.ack_req;
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_params(input logic [31:0] len, input logic [23:0] psn);
    dma_length  = len;
    rem_psn     = psn;
    r_key       = $urandom;
    rem_qpn     = 24'($urandom);
    rem_ip_addr = $urandom;
    rem_addr    = {$urandom, $urandom};
    hs_cnt      = 0;
    done_cnt    = 0;
    drop_cnt    = 0;
  endtask

  // Pulse start, then run until the model queue drains and the block is idle.
  task automatic run_transfer(input string tag, input int exp_pkts);
    int n;
    push_transfer(dma_length, rem_psn);
    start_transfer = 1'b1;
    tick();
    start_transfer = 1'b0;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      if (rand_ready) m_hdr_ready = 1'($urandom_range(0, 1));
      if (pending_done) done_cnt++;
      tick();
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 200), 64'd1);
    if (pending_done) done_cnt++;
    tick();
    check({tag, "_handshakes"}, 64'(hs_cnt), 64'(exp_pkts));
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    pending_done   = 1'b0;
    prev_stall     = 1'b0;
    rand_ready     = 1'b0;
    rst_n          = 1'b0;
    start_transfer = 1'b0;
    m_hdr_ready    = 1'b0;
    set_params(32'd0, 24'd0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",   m_hdr_valid,      1'b0);
    check("rst_busy",    busy,             1'b0);
    check("rst_done",    done,             1'b0);
    check("rst_dropped", start_dropped,    1'b0);
    check("rst_opcode",  m_bth_opcode,     8'h00);
    check("rst_payload", m_payload_length, 16'h0);
    rst_n = 1'b1;
    tick();

    // 4096 bytes, ready held: FIRST/MIDDLE/MIDDLE/LAST, with start latency
    set_params(32'd4096, 24'h10);
    m_hdr_ready = 1'b1;
    push_transfer(dma_length, rem_psn);
    start_transfer = 1'b1;
    tick();
    start_transfer = 1'b0;
    check("lat_busy_c1",  busy,        1'b1);
    check("lat_valid_c1", m_hdr_valid, 1'b0);
    tick();
    check("lat_valid_c2", m_hdr_valid, 1'b1);
    repeat (4) tick();
    check("t4096_busy", busy, 1'b0);
    check("t4096_done", done, 1'b1);
    tick();
    check("t4096_handshakes", 64'(hs_cnt), 64'd4);
    check("t4096_drained", 64'(exp_q.size()), 64'd0);

    // Single-packet transfers
    set_params(32'd100, 24'h123456);
    run_transfer("t100", 1);
    set_params(32'd0, 24'h000042);
    run_transfer("t0", 1);

    // PSN wrap
    set_params(32'd2500, 24'hFFFFFF);
    run_transfer("t2500", 3);

    // Random ready stalls on a 3-packet transfer
    rand_ready = 1'b1;
    set_params(32'd3000, 24'h000777);
    run_transfer("tstall", 3);
    rand_ready = 1'b0;
    m_hdr_ready = 1'b1;

    // Second start edge while busy, then start held high after done
    set_params(32'd4096, 24'h000100);
    push_transfer(dma_length, rem_psn);
    start_transfer = 1'b1;
    tick();
    start_transfer = 1'b0;
    tick();
    start_transfer = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (pending_done) done_cnt++;
      tick();
    end
    check("tdrop_handshakes", 64'(hs_cnt), 64'd4);
    check("tdrop_done_count", 64'(done_cnt), 64'd1);
    check("tdrop_drop_count", 64'(drop_cnt), 64'd1);
    check("tdrop_no_restart", busy, 1'b0);
    start_transfer = 1'b0;
    tick();

    // Reset while a MIDDLE descriptor is pending
    set_params(32'd4096, 24'h000200);
    m_hdr_ready = 1'b0;
    push_transfer(dma_length, rem_psn);
    start_transfer = 1'b1;
    tick();
    start_transfer = 1'b0;
    tick();
    m_hdr_ready = 1'b1;
    tick();
    m_hdr_ready = 1'b0;
    tick();
    tick();
    check("rmid_pending_opcode", m_bth_opcode, 8'h07);
    rst_n = 1'b0;
    #1;
    check("rmid_valid", m_hdr_valid, 1'b0);
    check("rmid_busy",  busy,        1'b0);
    exp_q.delete();
    prev_stall = 1'b0;
    tick();
    check("rmid_no_done", done, 1'b0);
    rst_n = 1'b1;
    tick();
    m_hdr_ready = 1'b1;
    set_params(32'd1500, 24'h000300);
    run_transfer("tafter_rst", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
